// File: rtl/pulse_transmitter_pkg.sv
// Shared definitions for the pulse-transmitter timer channels: mode and state
// encodings plus the prescaler-select width derivation.
package pulse_transmitter_pkg;

   localparam logic MODE_REPEAT  = 1'b0;
   localparam logic MODE_ONESHOT = 1'b1;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_COUNT = 1'b1
   } chan_state_t;

   // Bits needed to select any shift in 0..max_shift.
   function automatic int psw_of(input int max_shift);
      return $clog2(max_shift + 1);
   endfunction

endpackage

// File: rtl/pulse_transmitter_timer_channel.sv
// One prescaled countdown channel: period is (duration+1) << prescaler cycles,
// one-shot or repeating, with the FSM state exposed for observation.
module pulse_transmitter_timer_channel
   import pulse_transmitter_pkg::*;
#(
   parameter int PRESCALER_WIDTH = 15,
   parameter int TIMER_WIDTH     = 8,
   parameter int PSW             = psw_of(PRESCALER_WIDTH)
) (
   input  logic                   clk,
   input  logic                   sys_rst_n,
   input  logic                   en,
   input  logic                   start,
   input  logic                   oneshot,
   input  logic [PSW-1:0]         prescaler,
   input  logic [TIMER_WIDTH-1:0] duration,
   output chan_state_t            state,
   output logic                   pulse_out
);

   localparam logic [PRESCALER_WIDTH-1:0] ONES    = '1;
   localparam logic [PSW-1:0]             SEL_MAX = PSW'(PRESCALER_WIDTH);

   logic [PSW-1:0]             sel_live;
   logic [PSW-1:0]             sel_q;
   logic [PRESCALER_WIDTH-1:0] pre_cnt;
   logic [TIMER_WIDTH-1:0]     main_cnt;
   logic                       mode_q;
   logic                       expire;

   assign sel_live = (prescaler > SEL_MAX) ? SEL_MAX : prescaler;
   assign expire   = (state == ST_COUNT) && (pre_cnt == '0) && (main_cnt == '0);

   // Restart and repeat-expiry share the load path; a start on the expiry
   // edge takes that path too but suppresses the pulse.
   always_ff @(posedge clk) begin
      if (!sys_rst_n || !en) begin
         state     <= ST_IDLE;
         pre_cnt   <= '0;
         main_cnt  <= '0;
         sel_q     <= '0;
         mode_q    <= MODE_REPEAT;
         pulse_out <= 1'b0;
      end else if (start || (expire && mode_q == MODE_REPEAT)) begin
         state     <= ST_COUNT;
         main_cnt  <= duration;
         sel_q     <= sel_live;
         pre_cnt   <= ~(ONES << sel_live);
         mode_q    <= oneshot;
         pulse_out <= expire && !start;
      end else if (expire) begin
         state     <= ST_IDLE;
         pulse_out <= 1'b1;
      end else begin
         pulse_out <= 1'b0;
         if (state == ST_COUNT) begin
            if (pre_cnt == '0) begin
               main_cnt <= main_cnt - 1'b1;
               pre_cnt  <= ~(ONES << sel_q);
            end else begin
               pre_cnt <= pre_cnt - 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/pulse_transmitter_multi_timer.sv
// Array of independent prescaled countdown timers fed by packed per-channel
// parameter buses; busy is taken straight from each channel's state register.
module pulse_transmitter_multi_timer
   import pulse_transmitter_pkg::*;
#(
   parameter int NUM_CHANNELS    = 2,
   parameter int PRESCALER_WIDTH = 15,
   parameter int TIMER_WIDTH     = 8,
   localparam int PSW            = psw_of(PRESCALER_WIDTH)
) (
   input  logic                                clk,
   input  logic                                sys_rst_n,
   input  logic [NUM_CHANNELS-1:0]             en,
   input  logic [NUM_CHANNELS-1:0]             start,
   input  logic [NUM_CHANNELS-1:0]             oneshot,
   input  logic [NUM_CHANNELS*PSW-1:0]         prescaler,
   input  logic [NUM_CHANNELS*TIMER_WIDTH-1:0] duration,
   output logic [NUM_CHANNELS-1:0]             busy,
   output logic [NUM_CHANNELS-1:0]             pulse_out
);

   chan_state_t ch_state [NUM_CHANNELS];

   for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
      pulse_transmitter_timer_channel #(
         .PRESCALER_WIDTH (PRESCALER_WIDTH),
         .TIMER_WIDTH     (TIMER_WIDTH),
         .PSW             (PSW)
      ) u_channel (
         .clk       (clk),
         .sys_rst_n (sys_rst_n),
         .en        (en[i]),
         .start     (start[i]),
         .oneshot   (oneshot[i]),
         .prescaler (prescaler[i*PSW +: PSW]),
         .duration  (duration[i*TIMER_WIDTH +: TIMER_WIDTH]),
         .state     (ch_state[i]),
         .pulse_out (pulse_out[i])
      );

      assign busy[i] = (ch_state[i] == ST_COUNT);
   end

endmodule
